lc3_mem_arbiter: RTL and testbench

Sequences the single-ported unified LC3 memory between the fetch stage (instruction reads) and the execute stage (LD/LDR/LDI/ST/STR/STI data accesses).
Performs the two-phase pointer-then-access sequence for LDI/STI.
Generates the complete_instr and complete_data pulses consumed by the pipeline controller.
Sits between the fetch/execute stages and the memory model.

---
 rtl/lc3_pkg.sv | 21 ++
 rtl/lc3_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// Shared LC3 types: memory-arbiter FSM states and the data-access opcode
// classes used by the pipeline controller.
package lc3_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INSTR   = 3'd1,
    DATA    = 3'd2,
    IND_PTR = 3'd3,
    IND_ACC = 3'd4
  } arb_state_t;

  // Encoded as {ind, we} so a data request decodes directly into the opcode.
  typedef enum logic [1:0] {
    OP_LD  = 2'b00,
    OP_ST  = 2'b01,
    OP_LDI = 2'b10,
    OP_STI = 2'b11
  } op_t;

endpackage

// File: rtl/lc3_mem_arbiter.sv
// Shares the single-ported LC3 memory between instruction fetch and data
// accesses, including the pointer-then-access sequence for LDI/STI.
module lc3_mem_arbiter
  import lc3_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic [DATA_W-1:0] instr_rdata,
  output logic              complete_instr,
  input  logic              data_req,
  input  logic              data_we,
  input  logic              data_ind,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              complete_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [2:0]        arb_state
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t        state, state_d;
  logic              mem_req_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, instr_rdata_d, data_rdata_d;
  logic              complete_instr_d, complete_data_d;
  logic [3:0]        starve_cnt, starve_cnt_d;
  logic              lat_we, lat_we_d;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_d;

  logic instr_ok, data_ok, grant_instr, grant_data, ack;

  // A requester whose completion is pulsing this cycle is still holding its
  // old request; ignoring it avoids re-running the same transaction.
  assign instr_ok    = instr_req && !complete_instr;
  assign data_ok     = data_req && !complete_data;
  assign grant_instr = instr_ok && (!data_ok || starve_cnt == STARVE_LIM);
  assign grant_data  = data_ok && !grant_instr;
  assign ack         = mem_req && mem_ack;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d          = state;
    mem_req_d        = mem_req;
    mem_we_d         = mem_we;
    mem_addr_d       = mem_addr;
    mem_wdata_d      = mem_wdata;
    instr_rdata_d    = instr_rdata;
    data_rdata_d     = data_rdata;
    complete_instr_d = 1'b0;
    complete_data_d  = 1'b0;
    starve_cnt_d     = starve_cnt;
    lat_we_d         = lat_we;
    lat_wdata_d      = lat_wdata;

    unique case (state)
      IDLE: begin
        if (grant_instr) begin
          state_d      = INSTR;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = instr_addr;
          starve_cnt_d = '0;
        end else if (grant_data) begin
          state_d     = data_ind ? IND_PTR : DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = data_ind ? 1'b0 : data_we;
          mem_addr_d  = data_addr;
          mem_wdata_d = data_wdata;
          lat_we_d    = data_we;
          lat_wdata_d = data_wdata;
          if (instr_req && starve_cnt != STARVE_LIM) starve_cnt_d = starve_cnt + 4'd1;
        end
      end
      INSTR: begin
        if (ack) begin
          state_d          = IDLE;
          mem_req_d        = 1'b0;
          instr_rdata_d    = mem_rdata;
          complete_instr_d = 1'b1;
        end
      end
      IND_PTR: begin
        // The pointer parks in mem_addr during the one idle cycle.
        if (ack) begin
          state_d    = IND_ACC;
          mem_req_d  = 1'b0;
          mem_addr_d = mem_rdata;
        end
      end
      DATA, IND_ACC: begin
        if (!mem_req) begin
          mem_req_d   = 1'b1;
          mem_we_d    = lat_we;
          mem_wdata_d = lat_wdata;
        end else if (mem_ack) begin
          state_d         = IDLE;
          mem_req_d       = 1'b0;
          mem_we_d        = 1'b0;
          complete_data_d = 1'b1;
          if (!mem_we) data_rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      instr_rdata    <= '0;
      data_rdata     <= '0;
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
      starve_cnt     <= '0;
      lat_we         <= 1'b0;
      lat_wdata      <= '0;
    end else begin
      state          <= state_d;
      mem_req        <= mem_req_d;
      mem_we         <= mem_we_d;
      mem_addr       <= mem_addr_d;
      mem_wdata      <= mem_wdata_d;
      instr_rdata    <= instr_rdata_d;
      data_rdata     <= data_rdata_d;
      complete_instr <= complete_instr_d;
      complete_data  <= complete_data_d;
      starve_cnt     <= starve_cnt_d;
      lat_we         <= lat_we_d;
      lat_wdata      <= lat_wdata_d;
    end
  end

  assign arb_state = state;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter against a word-addressed memory model
// with a programmable number of wait cycles before mem_ack.
module tb_lc3_mem_arbiter;
  import lc3_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req;
  logic [15:0] instr_addr;
  logic [15:0] instr_rdata;
  logic        complete_instr;
  logic        data_req, data_we, data_ind;
  logic [15:0] data_addr, data_wdata, data_rdata;
  logic        complete_data;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  arb_state;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [0:65535];
  int          mem_wait = 0;
  int          wait_cnt = 0;

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_rdata(instr_rdata),
    .complete_instr(complete_instr),
    .data_req(data_req), .data_we(data_we), .data_ind(data_ind),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .complete_data(complete_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .arb_state(arb_state)
  );

  always #5 clk = ~clk;

  assign mem_ack   = mem_req && (wait_cnt >= mem_wait);
  assign mem_rdata = mem_req ? mem[mem_addr] : 16'h0000;

  always @(posedge clk) begin
    if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // {state, mem_req, complete_instr, complete_data}
  logic [5:0] snap;
  assign snap = {arb_state, mem_req, complete_instr, complete_data};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, instr_rdata, data_rdata,
         complete_instr, complete_data, arb_state} !== '0) begin
      failures++;
      $display("FAIL reset_outputs req=%b we=%b addr=%h wdata=%h irdata=%h drdata=%h ci=%b cd=%b st=%0d exp all zero",
               mem_req, mem_we, mem_addr, mem_wdata, instr_rdata, data_rdata,
               complete_instr, complete_data, arb_state);
    end
    rst = 1'b0;
    step();
    checks++;
    if (snap !== {IDLE, 3'b000}) begin
      failures++; $display("FAIL reset_idle snap=%h exp=%h", snap, {IDLE, 3'b000});
    end
  endtask

  task automatic test_fetch();
    mem[16'h3000] = 16'h1261;
    instr_req = 1'b1; instr_addr = 16'h3000;
    step();
    checks++;
    if (snap !== {INSTR, 3'b100} || mem_addr !== 16'h3000 || mem_we !== 1'b0) begin
      failures++; $display("FAIL fetch_issue snap=%h addr=%h we=%b exp snap=%h addr=3000 we=0",
                           snap, mem_addr, mem_we, {INSTR, 3'b100});
    end
    step();
    checks++;
    if (snap !== {IDLE, 3'b010} || instr_rdata !== 16'h1261) begin
      failures++; $display("FAIL fetch_complete snap=%h rdata=%h exp snap=%h rdata=1261",
                           snap, instr_rdata, {IDLE, 3'b010});
    end
    // instr_req still high while complete_instr pulses: must not re-trigger.
    step();
    checks++;
    if (snap !== {IDLE, 3'b000}) begin
      failures++; $display("FAIL fetch_guard snap=%h exp=%h", snap, {IDLE, 3'b000});
    end
    instr_req = 1'b0;
  endtask

  task automatic test_data_vs_fetch();
    mem[16'h4000] = 16'hBEEF;
    mem[16'h3001] = 16'h2222;
    data_req = 1'b1; {data_ind, data_we} = OP_LD; data_addr = 16'h4000;
    instr_req = 1'b1; instr_addr = 16'h3001;
    step();
    checks++;
    if (snap !== {DATA, 3'b100} || mem_addr !== 16'h4000 || mem_we !== 1'b0) begin
      failures++; $display("FAIL both_data_first snap=%h addr=%h we=%b exp snap=%h addr=4000 we=0",
                           snap, mem_addr, mem_we, {DATA, 3'b100});
    end
    step();
    checks++;
    if (snap !== {IDLE, 3'b001} || data_rdata !== 16'hBEEF) begin
      failures++; $display("FAIL both_data_done snap=%h rdata=%h exp snap=%h rdata=beef",
                           snap, data_rdata, {IDLE, 3'b001});
    end
    // data_req still held in the guard cycle; fetch must take the slot.
    step();
    checks++;
    if (snap !== {INSTR, 3'b100} || mem_addr !== 16'h3001) begin
      failures++; $display("FAIL both_fetch_grant snap=%h addr=%h exp snap=%h addr=3001",
                           snap, mem_addr, {INSTR, 3'b100});
    end
    data_req = 1'b0;
    step();
    checks++;
    if (snap !== {IDLE, 3'b010} || instr_rdata !== 16'h2222) begin
      failures++; $display("FAIL both_fetch_done snap=%h rdata=%h exp snap=%h rdata=2222",
                           snap, instr_rdata, {IDLE, 3'b010});
    end
    instr_req = 1'b0;
    step();
  endtask

  task automatic test_ldi();
    mem[16'h4010] = 16'h5000;
    mem[16'h5000] = 16'h00AA;
    data_req = 1'b1; {data_ind, data_we} = OP_LDI; data_addr = 16'h4010;
    step();
    checks++;
    if (snap !== {IND_PTR, 3'b100} || mem_addr !== 16'h4010 || mem_we !== 1'b0) begin
      failures++; $display("FAIL ldi_ptr snap=%h addr=%h we=%b exp snap=%h addr=4010 we=0",
                           snap, mem_addr, mem_we, {IND_PTR, 3'b100});
    end
    step();
    checks++;
    if (snap !== {IND_ACC, 3'b000}) begin
      failures++; $display("FAIL ldi_gap snap=%h exp=%h", snap, {IND_ACC, 3'b000});
    end
    step();
    checks++;
    if (snap !== {IND_ACC, 3'b100} || mem_addr !== 16'h5000 || mem_we !== 1'b0) begin
      failures++; $display("FAIL ldi_acc snap=%h addr=%h we=%b exp snap=%h addr=5000 we=0",
                           snap, mem_addr, mem_we, {IND_ACC, 3'b100});
    end
    step();
    checks++;
    if (snap !== {IDLE, 3'b001} || data_rdata !== 16'h00AA) begin
      failures++; $display("FAIL ldi_done snap=%h rdata=%h exp snap=%h rdata=00aa",
                           snap, data_rdata, {IDLE, 3'b001});
    end
    data_req = 1'b0;
    step();
  endtask

  task automatic test_sti();
    mem[16'h4020] = 16'h6000;
    mem[16'h6000] = 16'h0000;
    data_req = 1'b1; {data_ind, data_we} = OP_STI; data_addr = 16'h4020; data_wdata = 16'h1234;
    step();
    checks++;
    if (snap !== {IND_PTR, 3'b100} || mem_addr !== 16'h4020 || mem_we !== 1'b0) begin
      failures++; $display("FAIL sti_ptr snap=%h addr=%h we=%b exp snap=%h addr=4020 we=0",
                           snap, mem_addr, mem_we, {IND_PTR, 3'b100});
    end
    // Inputs change after the grant; the latched copies must be used.
    data_addr = 16'h0000; data_wdata = 16'hFFFF; data_we = 1'b0;
    step();
    checks++;
    if (snap !== {IND_ACC, 3'b000}) begin
      failures++; $display("FAIL sti_gap snap=%h exp=%h", snap, {IND_ACC, 3'b000});
    end
    step();
    checks++;
    if (snap !== {IND_ACC, 3'b100} || mem_addr !== 16'h6000 || mem_we !== 1'b1 || mem_wdata !== 16'h1234) begin
      failures++; $display("FAIL sti_acc snap=%h addr=%h we=%b wdata=%h exp snap=%h addr=6000 we=1 wdata=1234",
                           snap, mem_addr, mem_we, mem_wdata, {IND_ACC, 3'b100});
    end
    step();
    checks++;
    if (snap !== {IDLE, 3'b001} || data_rdata !== 16'h00AA || mem[16'h6000] !== 16'h1234) begin
      failures++; $display("FAIL sti_done snap=%h rdata=%h mem6000=%h exp snap=%h rdata=00aa mem6000=1234",
                           snap, data_rdata, mem[16'h6000], {IDLE, 3'b001});
    end
    data_req = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    mem[16'h4030] = 16'h0101;
    mem[16'h3002] = 16'h3333;
    data_req = 1'b1; {data_ind, data_we} = OP_LD; data_addr = 16'h4030;
    instr_addr = 16'h3002;
    for (int k = 0; k < 4; k++) begin
      instr_req = 1'b1;
      step();
      checks++;
      if (snap !== {DATA, 3'b100}) begin
        failures++; $display("FAIL starve_data_grant%0d snap=%h exp=%h", k, snap, {DATA, 3'b100});
      end
      instr_req = 1'b0;
      step();
      checks++;
      if (snap !== {IDLE, 3'b001} || data_rdata !== 16'h0101) begin
        failures++; $display("FAIL starve_data_done%0d snap=%h rdata=%h exp snap=%h rdata=0101",
                             k, snap, data_rdata, {IDLE, 3'b001});
      end
      step();
    end
    instr_req = 1'b1;
    step();
    checks++;
    if (snap !== {INSTR, 3'b100} || mem_addr !== 16'h3002) begin
      failures++; $display("FAIL starve_forced_instr snap=%h addr=%h exp snap=%h addr=3002",
                           snap, mem_addr, {INSTR, 3'b100});
    end
    step();
    checks++;
    if (snap !== {IDLE, 3'b010} || instr_rdata !== 16'h3333) begin
      failures++; $display("FAIL starve_instr_done snap=%h rdata=%h exp snap=%h rdata=3333",
                           snap, instr_rdata, {IDLE, 3'b010});
    end
    instr_req = 1'b0;
    step();
    checks++;
    if (snap !== {DATA, 3'b100}) begin
      failures++; $display("FAIL starve_resume_data snap=%h exp=%h", snap, {DATA, 3'b100});
    end
    step();
    step();
    // Counter must be back at 0: with both requesting, data wins again.
    instr_req = 1'b1;
    step();
    checks++;
    if (snap !== {DATA, 3'b100}) begin
      failures++; $display("FAIL starve_counter_cleared snap=%h exp=%h", snap, {DATA, 3'b100});
    end
    instr_req = 1'b0;
    step();
    data_req = 1'b0;
    step();
    checks++;
    if (snap !== {IDLE, 3'b000}) begin
      failures++; $display("FAIL starve_quiet snap=%h exp=%h", snap, {IDLE, 3'b000});
    end
  endtask

  task automatic test_reset_mid_indirect();
    mem_wait = 3;
    data_req = 1'b1; {data_ind, data_we} = OP_LDI; data_addr = 16'h4010;
    step();
    step();
    checks++;
    if (snap !== {IND_PTR, 3'b100}) begin
      failures++; $display("FAIL rstmid_waiting snap=%h exp=%h", snap, {IND_PTR, 3'b100});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (snap !== {IDLE, 3'b000}) begin
      failures++; $display("FAIL rstmid_async snap=%h exp=%h", snap, {IDLE, 3'b000});
    end
    data_req = 1'b0;
    step();
    step();
    checks++;
    if (snap !== {IDLE, 3'b000} || data_rdata !== 16'h0000) begin
      failures++; $display("FAIL rstmid_no_complete snap=%h rdata=%h exp snap=%h rdata=0000",
                           snap, data_rdata, {IDLE, 3'b000});
    end
    rst = 1'b0;
    mem_wait = 0;
    step();
    data_req = 1'b1; {data_ind, data_we} = OP_LD; data_addr = 16'h4000;
    step();
    checks++;
    if (snap !== {DATA, 3'b100} || mem_addr !== 16'h4000) begin
      failures++; $display("FAIL rstmid_new_ld snap=%h addr=%h exp snap=%h addr=4000",
                           snap, mem_addr, {DATA, 3'b100});
    end
    step();
    checks++;
    if (snap !== {IDLE, 3'b001} || data_rdata !== 16'hBEEF) begin
      failures++; $display("FAIL rstmid_ld_done snap=%h rdata=%h exp snap=%h rdata=beef",
                           snap, data_rdata, {IDLE, 3'b001});
    end
    data_req = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    instr_req = 1'b0; instr_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_ind = 1'b0;
    data_addr = '0; data_wdata = '0;
    test_reset();
    test_fetch();
    test_data_vs_fetch();
    test_ldi();
    test_sti();
    test_starvation();
    test_reset_mid_indirect();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
